wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back port arbiter for the csRISC core. It shares the single register-file write port between three result sources: load returns from memory, ALU results, and link (return-address) writes. Each cycle it picks one winner and registers that winner's data onto its lane of the write-back data mux. It drives the mux select `PCMemReg`, the register-file write enable and the write address. Grant order is fixed priority with anti-starvation for ALU results.

## Interface
Parameters:
- `STARVE_LIMIT`, 3: consecutive cycles an ALU request may lose to link before it is boosted above link (1..7).
- `ADDR_W`, 5: register address width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_valid`  in  1  load data return. No backpressure; must be accepted the same cycle.
- `mem_rd`  in  ADDR_W  load destination.
- `mem_rdata`  in  32  load data.
- `alu_valid`  in  1  ALU result request.
- `alu_ready`  out  1  ALU grant, combinational.
- `alu_rd`  in  ADDR_W  ALU destination.
- `alu_result`  in  32  ALU data.
- `link_valid`  in  1  link write request (JAL-type).
- `link_ready`  out  1  link grant, combinational.
- `link_rd`  in  ADDR_W  link destination.
- `link_pc`  in  32  byte PC. Passed through unshifted; the mux applies >>2.
- `alu_data`  out  32  registered ALU lane to the mux.
- `mem_data`  out  32  registered memory lane to the mux.
- `pc_data`  out  32  registered PC lane to the mux.
- `PCMemReg`  out  2  mux select: 00 ALU, 01 MEM, 10 PC.
- `reg_write`  out  1  register-file write enable.
- `write_reg_addr`  out  ADDR_W  register-file write address.
- `starve_boost`  out  1  high while the ALU is boosted above link (debug).

## Operation
- Grant per cycle, one winner at most:
  - `mem_valid` always wins.
  - Otherwise, if `starve_boost` is set and `alu_valid`: ALU wins.
  - Otherwise link, then ALU.
- `alu_ready` and `link_ready` are asserted only for the winner. A requester holds valid, rd and data stable until its ready is seen; the transfer occurs on the valid&&ready edge.
- On a transfer edge:
  - The winner's data is registered onto its own lane. The other lanes hold their previous values.
  - `PCMemReg` is set to the winner's code.
  - `write_reg_addr` is set to the winner's rd.
  - `reg_write` is set to 1 if rd != 0, else 0. An x0 write is consumed but suppressed.
- No transfer: `reg_write` is 0. `PCMemReg`, `write_reg_addr` and the lanes hold.
- Starvation counter `alu_wait`, 3 bits, saturating at 7:
  - Increments when `alu_valid` && !`alu_ready` && the cycle was won by link.
  - Clears on an ALU transfer or when `alu_valid` is 0.
  - Losses to mem do not count.
- `starve_boost` = (`alu_wait` >= `STARVE_LIMIT`).
- Controller states:
  - IDLE: `reg_write` low.
  - WRITE: one-cycle registered write.
  - WRITE is entered on any transfer. It returns to IDLE on a cycle with no transfer and stays in WRITE on back-to-back transfers.
  - `reg_write` is 1 exactly in WRITE with a non-zero address.

## Timing
- Latency: a transfer at edge N drives `reg_write`/address/select/lane for cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle.
- Reset (synchronous, at an edge with `rst`=1):
  - Cleared outputs: `reg_write`, `PCMemReg`, `write_reg_addr`, all three lanes, `alu_wait`, `starve_boost`.
  - State goes to IDLE.
  - `alu_ready` and `link_ready` are 0 while `rst` is high.
- Reset mid-operation: a write registered in the previous cycle is still presented for the cycle it occupies; reset only clears it at the next edge. Grants are blocked during reset, so held requests are not lost.
- Simultaneous mem + link + ALU: mem wins. Link and ALU both stall; `alu_wait` is unchanged.
- Link saturation: if link is valid every cycle, the ALU wins no later than `STARVE_LIMIT`+1 cycles after its request first loses to link, mem permitting.
- A mem return to x0 produces a cycle with `reg_write`=0 and still blocks the other requesters.

## Structure
- Shared package `csrisc_pkg`:
  - select codes `WB_SEL_ALU`=2'b00, `WB_SEL_MEM`=2'b01, `WB_SEL_PC`=2'b10.
  - `ADDR_W` default.
  - state encoding IDLE/WRITE.
- One natural sub-module, `wb_starve_ctr`: the saturating counter plus threshold compare.
- Arbitration and output registers stay in the top.

## Test plan
- Reset: hold `rst` 2 cycles with all valids high -> `reg_write`=0, `PCMemReg`=00, all lanes 0, both readies 0.
- Priority: mem(rd=3, data=0xAAAA_0001) + link(rd=31, pc=0x100) + alu(rd=4) in one cycle -> next cycle `reg_write`=1, addr=3, `PCMemReg`=01, `mem_data`=0xAAAA_0001. Link and ALU are granted on the following cycles, link first, with `pc_data`=0x100.
- Starvation: link valid continuously, ALU valid (rd=5, 0x1234), `STARVE_LIMIT`=3 -> link wins 3 cycles, `starve_boost` rises, ALU is granted on the 4th cycle, then `alu_wait` returns to 0.
- x0 suppression: ALU rd=0, data 0xFFFF_FFFF -> `alu_ready`=1 and `alu_data` updates, but `reg_write`=0 the next cycle.
- Back-to-back: ALU writes to rd=1,2,3 on consecutive cycles -> `reg_write` stays high 3 cycles with addresses 1,2,3 and `PCMemReg`=00 throughout.
- Mid-operation reset: assert `rst` one cycle after a link grant -> the write is presented that cycle, then all outputs clear. The held ALU request is granted after reset deasserts.

Source files
------------

// File: rtl/csrisc_pkg.sv
// ---------------------------------------------------------------------------
// csrisc_pkg
// Shared definitions for the csRISC write-back path:
//   - write-back mux select codes (PCMemReg encoding)
//   - default register address width
//   - write-back controller state encoding
// ---------------------------------------------------------------------------
package csrisc_pkg;

  // Write-back mux select codes driven on PCMemReg
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  // Default register-file address width (32 architectural registers)
  localparam int ADDR_W_DEFAULT = 5;

  // Write-back controller states
  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;

endpackage : csrisc_pkg

// File: rtl/wb_starve_ctr.sv
// ---------------------------------------------------------------------------
// wb_starve_ctr
// Counts consecutive cycles a pending ALU result has lost arbitration to a
// link write, and raises starve_boost once the count reaches STARVE_LIMIT.
//
// Ports:
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   alu_valid    in   ALU result is requesting the write port
//   alu_xfer     in   ALU result transferred this cycle
//   link_win     in   link write won the port this cycle
//   alu_wait     out  3-bit saturating loss count
//   starve_boost out  ALU is currently boosted above link
// ---------------------------------------------------------------------------
module wb_starve_ctr #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  logic       alu_xfer,
  input  logic       link_win,
  output logic [2:0] alu_wait,
  output logic       starve_boost
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  // Only losses to link are counted; a cycle taken by a memory return leaves
  // the count untouched so that mem traffic cannot trigger a boost on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wait <= 3'd0;
    end else if (!alu_valid || alu_xfer) begin
      alu_wait <= 3'd0;
    end else if (link_win && (alu_wait != 3'd7)) begin
      alu_wait <= alu_wait + 3'd1;
    end
  end

  assign starve_boost = (alu_wait >= LIMIT);

endmodule : wb_starve_ctr

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between memory load returns,
// ALU results and link (return address) writes. One winner per cycle; its
// data is registered onto its own lane of the write-back mux, and the mux
// select, write address and write enable are presented the following cycle.
// Priority: mem > (boosted ALU) > link > ALU.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_valid/mem_rd/mem_rdata     load return (no backpressure)
//   alu_valid/alu_ready/alu_rd/alu_result   ALU result handshake
//   link_valid/link_ready/link_rd/link_pc   link write handshake
//   alu_data/mem_data/pc_data      registered mux lanes
//   PCMemReg                       mux select (00 ALU, 01 MEM, 10 PC)
//   reg_write/write_reg_addr       register-file write enable and address
//   starve_boost                   ALU boosted above link (debug)
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import csrisc_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_W       = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [31:0]       alu_result,
  input  logic              link_valid,
  output logic              link_ready,
  input  logic [ADDR_W-1:0] link_rd,
  input  logic [31:0]       link_pc,
  output logic [31:0]       alu_data,
  output logic [31:0]       mem_data,
  output logic [31:0]       pc_data,
  output logic [1:0]        PCMemReg,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg_addr,
  output logic              starve_boost
);

  wb_state_t   state;
  wb_state_t   next_state;
  logic        mem_xfer;
  logic        alu_xfer;
  logic        link_xfer;
  logic        any_xfer;
  logic [2:0]  alu_wait;

  // Grant logic. Reset blocks every grant so held requests survive a reset.
  // A memory return has no backpressure and always takes the port.
  always_comb begin
    mem_xfer   = 1'b0;
    alu_ready  = 1'b0;
    link_ready = 1'b0;
    if (!rst) begin
      if (mem_valid) begin
        mem_xfer = 1'b1;
      end else if (starve_boost && alu_valid) begin
        alu_ready = 1'b1;
      end else if (link_valid) begin
        link_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end
    end
  end

  assign alu_xfer  = alu_valid && alu_ready;
  assign link_xfer = link_valid && link_ready;
  assign any_xfer  = mem_xfer || alu_xfer || link_xfer;

  wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_xfer     (alu_xfer),
    .link_win     (link_xfer),
    .alu_wait     (alu_wait),
    .starve_boost (starve_boost)
  );

  // Lane, select and address registers. Only the winner's lane is loaded;
  // the other lanes and the select/address hold when nothing transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data       <= 32'd0;
      mem_data       <= 32'd0;
      pc_data        <= 32'd0;
      PCMemReg       <= WB_SEL_ALU;
      write_reg_addr <= '0;
    end else if (mem_xfer) begin
      mem_data       <= mem_rdata;
      PCMemReg       <= WB_SEL_MEM;
      write_reg_addr <= mem_rd;
    end else if (link_xfer) begin
      pc_data        <= link_pc;
      PCMemReg       <= WB_SEL_PC;
      write_reg_addr <= link_rd;
    end else if (alu_xfer) begin
      alu_data       <= alu_result;
      PCMemReg       <= WB_SEL_ALU;
      write_reg_addr <= alu_rd;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every transfer lands in WRITE for exactly the following cycle; an x0
  // destination is consumed but the write enable is suppressed.
  always_comb begin
    next_state = WB_IDLE;
    reg_write  = 1'b0;
    if (any_xfer) begin
      next_state = WB_WRITE;
    end
    if ((state == WB_WRITE) && (write_reg_addr != '0)) begin
      reg_write = 1'b1;
    end
  end

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed bench for wb_port_arbiter with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_rdata;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        link_valid;
  logic        link_ready;
  logic [4:0]  link_rd;
  logic [31:0] link_pc;
  logic [31:0] alu_data;
  logic [31:0] mem_data;
  logic [31:0] pc_data;
  logic [1:0]  PCMemReg;
  logic        reg_write;
  logic [4:0]  write_reg_addr;
  logic        starve_boost;

  int total;
  int bad;

  wb_port_arbiter #(
    .STARVE_LIMIT (3),
    .ADDR_W       (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_rd         (mem_rd),
    .mem_rdata      (mem_rdata),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_result     (alu_result),
    .link_valid     (link_valid),
    .link_ready     (link_ready),
    .link_rd        (link_rd),
    .link_pc        (link_pc),
    .alu_data       (alu_data),
    .mem_data       (mem_data),
    .pc_data        (pc_data),
    .PCMemReg       (PCMemReg),
    .reg_write      (reg_write),
    .write_reg_addr (write_reg_addr),
    .starve_boost   (starve_boost)
  );

  // 10 ns core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive every requester input in one call.
  task automatic applyStimulus(input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                               input logic av, input logic [4:0] ard, input logic [31:0] adat,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] lpc);
    mem_valid  = mv;
    mem_rd     = mrd;
    mem_rdata  = mdat;
    alu_valid  = av;
    alu_rd     = ard;
    alu_result = adat;
    link_valid = lv;
    link_rd    = lrd;
    link_pc    = lpc;
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Combinational readies are sampled mid-cycle on the falling edge.
  task automatic midCycle();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b1, 5'd6, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222,
                  1'b1, 5'd8, 32'h3333_3333);

    // Reset held two cycles with all requesters active
    step();
    midCycle();
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("rst_link_ready", 32'(link_ready), 32'd0);
    step();
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_sel", 32'(PCMemReg), 32'd0);
    checkOutput("rst_addr", 32'(write_reg_addr), 32'd0);
    checkOutput("rst_alu_data", alu_data, 32'd0);
    checkOutput("rst_mem_data", mem_data, 32'd0);
    checkOutput("rst_pc_data", pc_data, 32'd0);
    checkOutput("rst_boost", 32'(starve_boost), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    step();

    // Priority: all three at once, mem first, then link, then ALU
    $display("[TB] priority");
    applyStimulus(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd4, 32'h0000_0055,
                  1'b1, 5'd31, 32'h0000_0100);
    midCycle();
    checkOutput("pri_alu_blocked", 32'(alu_ready), 32'd0);
    checkOutput("pri_link_blocked", 32'(link_ready), 32'd0);
    step();
    checkOutput("pri_mem_we", 32'(reg_write), 32'd1);
    checkOutput("pri_mem_addr", 32'(write_reg_addr), 32'd3);
    checkOutput("pri_mem_sel", 32'(PCMemReg), 32'h1);
    checkOutput("pri_mem_data", mem_data, 32'hAAAA_0001);
    mem_valid = 1'b0;
    midCycle();
    checkOutput("pri_link_ready", 32'(link_ready), 32'd1);
    checkOutput("pri_alu_wait", 32'(alu_ready), 32'd0);
    step();
    checkOutput("pri_link_we", 32'(reg_write), 32'd1);
    checkOutput("pri_link_addr", 32'(write_reg_addr), 32'd31);
    checkOutput("pri_link_sel", 32'(PCMemReg), 32'h2);
    checkOutput("pri_pc_data", pc_data, 32'h0000_0100);
    checkOutput("pri_mem_hold", mem_data, 32'hAAAA_0001);
    link_valid = 1'b0;
    midCycle();
    checkOutput("pri_alu_ready", 32'(alu_ready), 32'd1);
    step();
    checkOutput("pri_alu_addr", 32'(write_reg_addr), 32'd4);
    checkOutput("pri_alu_sel", 32'(PCMemReg), 32'h0);
    checkOutput("pri_alu_data", alu_data, 32'h0000_0055);
    alu_valid = 1'b0;
    step();
    checkOutput("idle_we", 32'(reg_write), 32'd0);
    checkOutput("idle_addr_hold", 32'(write_reg_addr), 32'd4);
    checkOutput("idle_pc_hold", pc_data, 32'h0000_0100);

    // Starvation: link every cycle, ALU boosted after three losses
    $display("[TB] starvation");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234,
                  1'b1, 5'd7, 32'h0000_0200);
    for (int i = 1; i <= 3; i++) begin
      midCycle();
      checkOutput($sformatf("starve_link_ready%0d", i), 32'(link_ready), 32'd1);
      checkOutput($sformatf("starve_alu_lose%0d", i), 32'(alu_ready), 32'd0);
      step();
      checkOutput($sformatf("starve_boost%0d", i), 32'(starve_boost), (i == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("starve_link_addr%0d", i), 32'(write_reg_addr), 32'd7);
    end
    midCycle();
    checkOutput("starve_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("starve_link_held", 32'(link_ready), 32'd0);
    step();
    checkOutput("starve_alu_addr", 32'(write_reg_addr), 32'd5);
    checkOutput("starve_alu_sel", 32'(PCMemReg), 32'h0);
    checkOutput("starve_alu_data", alu_data, 32'h0000_1234);
    checkOutput("starve_boost_clear", 32'(starve_boost), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();

    // x0 destination: consumed, lane updated, write suppressed
    $display("[TB] x0 suppression");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF,
                  1'b0, 5'd0, 32'd0);
    midCycle();
    checkOutput("x0_alu_ready", 32'(alu_ready), 32'd1);
    step();
    checkOutput("x0_alu_data", alu_data, 32'hFFFF_FFFF);
    checkOutput("x0_we", 32'(reg_write), 32'd0);
    applyStimulus(1'b1, 5'd0, 32'hDEAD_0000, 1'b1, 5'd2, 32'h0000_0077,
                  1'b0, 5'd0, 32'd0);
    midCycle();
    checkOutput("x0_mem_blocks_alu", 32'(alu_ready), 32'd0);
    step();
    checkOutput("x0_mem_we", 32'(reg_write), 32'd0);
    checkOutput("x0_mem_sel", 32'(PCMemReg), 32'h1);
    checkOutput("x0_mem_data", mem_data, 32'hDEAD_0000);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();

    // Back-to-back ALU writes to x1, x2, x3
    $display("[TB] back-to-back");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h11 * i,
                    1'b0, 5'd0, 32'd0);
      step();
      checkOutput($sformatf("b2b_we%0d", i), 32'(reg_write), 32'd1);
      checkOutput($sformatf("b2b_addr%0d", i), 32'(write_reg_addr), 32'(i));
      checkOutput($sformatf("b2b_sel%0d", i), 32'(PCMemReg), 32'h0);
      checkOutput($sformatf("b2b_data%0d", i), alu_data, 32'h11 * i);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    checkOutput("b2b_end_we", 32'(reg_write), 32'd0);

    // Reset one cycle after a link grant; held ALU request survives
    $display("[TB] mid-operation reset");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_BEEF,
                  1'b1, 5'd9, 32'h0000_0300);
    midCycle();
    checkOutput("mrst_link_ready", 32'(link_ready), 32'd1);
    step();
    link_valid = 1'b0;
    rst        = 1'b1;
    checkOutput("mrst_we_presented", 32'(reg_write), 32'd1);
    checkOutput("mrst_addr_presented", 32'(write_reg_addr), 32'd9);
    checkOutput("mrst_sel_presented", 32'(PCMemReg), 32'h2);
    checkOutput("mrst_pc_presented", pc_data, 32'h0000_0300);
    midCycle();
    checkOutput("mrst_alu_blocked", 32'(alu_ready), 32'd0);
    step();
    checkOutput("mrst_we_clr", 32'(reg_write), 32'd0);
    checkOutput("mrst_addr_clr", 32'(write_reg_addr), 32'd0);
    checkOutput("mrst_sel_clr", 32'(PCMemReg), 32'h0);
    checkOutput("mrst_pc_clr", pc_data, 32'd0);
    checkOutput("mrst_alu_clr", alu_data, 32'd0);
    checkOutput("mrst_mem_clr", mem_data, 32'd0);
    rst = 1'b0;
    midCycle();
    checkOutput("mrst_alu_ready", 32'(alu_ready), 32'd1);
    step();
    checkOutput("mrst_alu_we", 32'(reg_write), 32'd1);
    checkOutput("mrst_alu_addr", 32'(write_reg_addr), 32'd10);
    checkOutput("mrst_alu_data", alu_data, 32'h0000_BEEF);
    alu_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_port_arbiter
